// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and sizing helpers for the memory arbiter.
package mem_arb_pkg;
    localparam int MAX_IDX_W = 3;
    typedef enum logic {ARB, LOCKED} arb_state_t;
    typedef struct packed {
        logic                 vld;
        logic [MAX_IDX_W-1:0] idx;
    } tag_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; the first set request at or after start wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    int c;
    // Scan farthest-to-nearest so the nearest requester overwrites any earlier hit.
    always_comb begin
        gnt = '0;
        idx = '0;
        c   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(start) + k;
            if (c >= N) c = c - N;
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter with lock that drives one single-port memory
// and returns read data tagged with the requester that issued the read.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               we,
    input  logic [NUM_REQ-1:0]               lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic                             mem_wr_en,
    output logic                             mem_rd_en,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);
    localparam int IW = idx_w(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    arb_state_t         state;
    logic [IW-1:0]      last, owner, start, win;
    logic [NUM_REQ-1:0] elig;
    logic               accept;
    tag_t               t1, t2;

    // While locked, the search starts at the owner and every other requester is masked.
    assign start  = (state == LOCKED) ? owner : (last == LAST_IDX) ? '0 : last + IW'(1);
    assign elig   = ((state == LOCKED) ? req & (NUM_REQ'(1) << owner) : req) & {NUM_REQ{reset}};
    assign accept = |gnt;
    assign rvalid = t2.vld ? NUM_REQ'(1) << t2.idx : '0;
    assign rdata  = mem_rdata;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (elig),
        .start (start),
        .gnt   (gnt),
        .idx   (win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            last      <= LAST_IDX;
            owner     <= '0;
            t1        <= '0;
            t2        <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
        end else begin
            mem_wr_en <= accept & we[win];
            mem_rd_en <= accept & ~we[win];
            t1        <= '{vld: accept & ~we[win], idx: MAX_IDX_W'(win)};
            t2        <= t1;
            if (accept) begin
                mem_addr  <= addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata <= wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                last      <= win;
                if (state == ARB && lock[win]) begin
                    state <= LOCKED;
                    owner <= win;
                end else if (state == LOCKED && !lock[win]) begin
                    state <= ARB;
                end
            end
        end
    end
endmodule
